// File: rtl/uartb_pkg.sv
// Shared types and sizing for the uartb transmitter/receiver pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: divider width, burst depth, TX/RX state encodings and the
// mid-bit offset helper used by the receiver.
package uartb_pkg;

  // Width of the bit-period divider; a bit lasts (divider + 1) clocks.
  localparam int DIV_W       = 9;

  // Number of bytes loaded by one transmit write in burst mode.
  localparam int BURST_BYTES = 4;

  // Pending-byte counter must hold 0..BURST_BYTES.
  localparam int PEND_W      = $clog2(BURST_BYTES + 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Offset from the start of a bit to its sampling point (truncated half).
  function automatic logic [DIV_W-1:0] mid_bit(input logic [DIV_W-1:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/uartb_rx.sv
// Serial receiver: 8N1 frames sampled at mid-bit into a one-deep buffer.
// Latency: q/dv update at the stop-bit sample, ~3 clocks of sync plus half a bit after stop begins.
// Backpressure: none; an unread byte is overwritten and flagged with o_ove.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_div       : current bit-period divider (bit = i_div + 1 clocks)
//   i_rxd       : raw serial input, idle high
//   i_rd        : CPU has consumed o_q; clears o_dv and o_ove
//   o_q         : last received byte
//   o_dv        : o_q holds an unread byte
//   o_fe        : stop bit of the last frame was low
//   o_ove       : a byte arrived while the previous one was still unread
module uartb_rx
  import uartb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_rxd,
  input  logic             i_rd,
  output logic [7:0]       o_q,
  output logic             o_dv,
  output logic             o_fe,
  output logic             o_ove
);

  // Two-flop synchroniser plus one history flop for edge detection.
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_done;
  logic             w_fall;
  logic [DIV_W-1:0] w_half;

  logic [7:0]       r_q;
  logic             r_dv;
  logic             r_fe;
  logic             r_ove;

  assign w_fall = r_prev & ~r_sync2;
  assign w_half = mid_bit(i_div);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_bit_nxt = 3'd0;
          // The cycle the edge is seen is already clock 0 of the start bit.
          // With a zero mid-bit offset that clock is itself the start-bit
          // sample, so go straight to data.
          if (w_half == '0) begin
            w_state_nxt = RX_DATA;
            w_cnt_nxt   = i_div;
          end else begin
            w_state_nxt = RX_START;
            w_cnt_nxt   = w_half - DIV_W'(1);
          end
        end
      end
      RX_START: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end else if (r_sync2) begin
          // Line is high again at mid-bit: treat as a glitch.
          w_state_nxt = RX_IDLE;
        end else begin
          w_state_nxt = RX_DATA;
          w_cnt_nxt   = i_div;
        end
      end
      RX_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end else begin
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          w_cnt_nxt   = i_div;
          if (r_bit == 3'd7) begin
            w_state_nxt = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end else begin
          w_done      = 1'b1;
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Frame completion takes priority over a coincident read: the new byte
  // is valid, and the read only suppresses the overrun it would cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_dv  <= 1'b0;
      r_fe  <= 1'b0;
      r_ove <= 1'b0;
    end else if (w_done) begin
      r_q   <= r_shift;
      r_dv  <= 1'b1;
      r_fe  <= ~r_sync2;
      r_ove <= (r_dv | r_ove) & ~i_rd;
    end else if (i_rd) begin
      r_dv  <= 1'b0;
      r_ove <= 1'b0;
    end
  end

  assign o_q   = r_q;
  assign o_dv  = r_dv;
  assign o_fe  = r_fe;
  assign o_ove = r_ove;

endmodule

// File: rtl/uartb_core.sv
// UART core: config register, 1/4-byte transmit holding register, TX FSM and receiver.
// Latency: start bit on txd one clock after the wrtx edge; rx byte at the stop-bit sample.
// Backpressure: wrtx is accepted only while thre=1 and dropped otherwise; rx overrun is flagged.
//
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   d               : CPU write data
//   wrtx            : load holding register (d[7:0], or all four bytes in burst mode)
//   wrbaud          : load config, d[8:0] = divider, d[31] = burst mode
//   txd             : serial output, idle high
//   thre, tend      : holding register empty / transmitter fully idle
//   rxd, rd         : serial input / CPU has read q
//   q, dv, fe, ove  : receive byte, valid, framing error, overrun
module uartb_core
  import uartb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d,
  input  logic        wrtx,
  input  logic        wrbaud,
  output logic        txd,
  output logic        thre,
  output logic        tend,
  input  logic        rxd,
  input  logic        rd,
  output logic [7:0]  q,
  output logic        dv,
  output logic        fe,
  output logic        ove
);

  // Config
  logic [DIV_W-1:0]  r_div;
  logic              r_mode;

  // Holding register: next byte to send always sits in r_hold[7:0].
  logic [31:0]       r_hold;
  logic [PEND_W-1:0] r_pend;

  // Transmitter
  tx_state_t         r_tx_state;
  tx_state_t         w_tx_state_nxt;
  logic [DIV_W-1:0]  r_tx_cnt;
  logic [DIV_W-1:0]  w_tx_cnt_nxt;
  logic [2:0]        r_tx_bit;
  logic [2:0]        w_tx_bit_nxt;
  logic [7:0]        r_tx_shift;
  logic [7:0]        w_tx_shift_nxt;
  logic              w_load;
  logic              w_accept;
  logic              w_txd;

  assign thre     = (r_pend == '0);
  assign tend     = (r_tx_state == TX_IDLE) && thre;
  assign w_accept = wrtx & thre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_mode <= 1'b0;
    end else if (wrbaud) begin
      r_div  <= d[DIV_W-1:0];
      r_mode <= d[31];
    end
  end

  // Accept and load are exclusive: a load needs r_pend != 0, which means
  // thre = 0 and any wrtx in that cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_pend <= '0;
    end else if (w_accept) begin
      r_hold <= d;
      r_pend <= r_mode ? PEND_W'(BURST_BYTES) : PEND_W'(1);
    end else if (w_load) begin
      r_hold <= {8'h00, r_hold[31:8]};
      r_pend <= r_pend - PEND_W'(1);
    end
  end

  // Every bit boundary reloads the counter from the live divider, so a
  // config write mid-frame takes effect from the next bit onward.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_load         = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_pend != '0) begin
          w_load         = 1'b1;
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = r_div;
          w_tx_shift_nxt = r_hold[7:0];
        end
      end
      TX_START: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - DIV_W'(1);
        end else begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = r_div;
          w_tx_bit_nxt   = 3'd0;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - DIV_W'(1);
        end else begin
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_cnt_nxt   = r_div;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - DIV_W'(1);
        end else if (r_pend != '0) begin
          // Chain straight into the next start bit: no idle gap.
          w_load         = 1'b1;
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = r_div;
          w_tx_shift_nxt = r_hold[7:0];
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
    end
  end

  // txd decodes registered state only, so reset forces it high at once.
  always_comb begin
    w_txd = 1'b1;
    case (r_tx_state)
      TX_START: w_txd = 1'b0;
      TX_DATA:  w_txd = r_tx_shift[0];
      default:  w_txd = 1'b1;
    endcase
  end

  assign txd = w_txd;

  uartb_rx u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .i_div (r_div),
    .i_rxd (rxd),
    .i_rd  (rd),
    .o_q   (q),
    .o_dv  (dv),
    .o_fe  (fe),
    .o_ove (ove)
  );

endmodule

// File: tb/tb_uartb_core.sv
// Directed bench for uartb_core with txd looped back to rxd (switchable to a driven line).
// Latency: n/a.
// Backpressure: n/a.
module tb_uartb_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] d;
  logic        wrtx;
  logic        wrbaud;
  logic        txd;
  logic        thre;
  logic        tend;
  logic        rxd;
  logic        rd;
  logic [7:0]  q;
  logic        dv;
  logic        fe;
  logic        ove;

  logic        loop_en;
  logic        drv_rxd;

  int n_err;
  int n_chk;

  assign rxd = loop_en ? txd : drv_rxd;

  uartb_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .wrtx   (wrtx),
    .wrbaud (wrbaud),
    .txd    (txd),
    .thre   (thre),
    .tend   (tend),
    .rxd    (rxd),
    .rd     (rd),
    .q      (q),
    .dv     (dv),
    .fe     (fe),
    .ove    (ove)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [31:0] v);
    @(negedge clk);
    d      = v;
    wrbaud = 1'b1;
    @(negedge clk);
    wrbaud = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    @(negedge clk);
    d    = v;
    wrtx = 1'b1;
    @(negedge clk);
    wrtx = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic wait_dv(input string tag);
    int t;
    t = 0;
    while (!dv && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " dv"}, dv, 1);
  endtask

  task automatic wait_thre();
    int t;
    t = 0;
    while (!thre && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("thre returns", thre, 1);
  endtask

  task automatic wait_tend();
    int t;
    t = 0;
    while (!tend && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("tend returns", tend, 1);
  endtask

  // Drive one raw frame on rxd at 8 clocks per bit.
  task automatic send_raw(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drv_rxd = fr[i];
      cycles(7);
    end
    if (!stop) cycles(8);
    @(negedge clk);
    drv_rxd = 1'b1;
    cycles(16);
  endtask

  logic [9:0] f0;
  logic [9:0] f1;
  logic [7:0] got [4];
  int         t;
  int         n;
  int         thre_at;

  initial begin
    n_err   = 0;
    n_chk   = 0;
    rst_n   = 1'b0;
    d       = '0;
    wrtx    = 1'b0;
    wrbaud  = 1'b0;
    rd      = 1'b0;
    loop_en = 1'b1;
    drv_rxd = 1'b1;

    // Reset state
    cycles(3);
    chk("rst txd", txd, 1);
    chk("rst thre", thre, 1);
    chk("rst tend", tend, 1);
    chk("rst q", q, 0);
    chk("rst dv", dv, 0);
    chk("rst fe", fe, 0);
    chk("rst ove", ove, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Normal byte 0xAA at 8 clocks per bit
    cfg(32'h0000_0007);
    send(32'h0000_00AA);
    chk("thre after wrtx", thre, 0);
    chk("tend after wrtx", tend, 0);
    t = 0;
    while (txd && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("start bit within 2 clocks", (t <= 2), 1);
    for (int i = 0; i < 10; i++) begin
      f0[i] = txd;
      cycles(7);
      f1[i] = txd;
      cycles(1);
    end
    chk("frame bit first clock", f0, 10'h354);
    chk("frame bit last clock", f1, 10'h354);
    wait_dv("aa");
    chk("aa q", q, 8'hAA);
    chk("aa fe", fe, 0);
    wait_tend();
    pulse_rd();
    chk("rd clears dv", dv, 0);

    // Back-to-back 0x55 then 0xC3
    send(32'h0000_0055);
    wait_thre();
    send(32'h0000_00C3);
    wait_dv("b2b first");
    chk("b2b q 55", q, 8'h55);
    chk("b2b fe", fe, 0);
    chk("b2b ove", ove, 0);
    pulse_rd();
    wait_dv("b2b second");
    chk("b2b q C3", q, 8'hC3);
    chk("b2b ove 2", ove, 0);
    pulse_rd();
    wait_tend();

    // Burst of four bytes; mode is switched back to normal mid-burst
    cfg(32'h8000_0007);
    send(32'h1122_3344);
    chk("burst thre low", thre, 0);
    fork
      begin
        t = 0;
        while (txd && t < 8) begin
          @(negedge clk);
          t++;
        end
        n       = 0;
        thre_at = -1;
        while (!tend && n < 1000) begin
          if (thre && thre_at < 0) thre_at = n;
          n++;
          @(negedge clk);
        end
        chk("burst total clocks", n, 320);
        chk("burst thre at last load", thre_at, 240);
      end
      begin
        cfg(32'h0000_0007);
        for (int i = 0; i < 4; i++) begin
          wait_dv("burst");
          got[i] = q;
          pulse_rd();
        end
      end
    join
    chk("burst byte0", got[0], 8'h44);
    chk("burst byte1", got[1], 8'h33);
    chk("burst byte2", got[2], 8'h22);
    chk("burst byte3", got[3], 8'h11);

    // Overrun: two bytes, no read in between
    send(32'h0000_003C);
    wait_thre();
    send(32'h0000_0096);
    wait_dv("ovr first");
    wait_tend();
    cycles(10);
    chk("ovr ove", ove, 1);
    chk("ovr q", q, 8'h96);
    chk("ovr dv", dv, 1);
    pulse_rd();
    chk("ovr rd clears dv", dv, 0);
    chk("ovr rd clears ove", ove, 0);

    // Framing error, glitch rejection and recovery on a driven line
    loop_en = 1'b0;
    send_raw(8'hE7, 1'b0);
    wait_dv("fe frame");
    chk("fe set", fe, 1);
    chk("fe byte stored", q, 8'hE7);
    pulse_rd();
    chk("fe persists after rd", fe, 1);
    @(negedge clk);
    drv_rxd = 1'b0;
    cycles(2);
    drv_rxd = 1'b1;
    cycles(100);
    chk("glitch ignored", dv, 0);
    send_raw(8'h18, 1'b1);
    wait_dv("fe clear frame");
    chk("fe cleared by good frame", fe, 0);
    chk("good frame q", q, 8'h18);
    pulse_rd();
    loop_en = 1'b1;

    // Divider 0: one clock per bit
    cfg(32'h0000_0000);
    send(32'h0000_005A);
    wait_dv("div0");
    chk("div0 q", q, 8'h5A);
    chk("div0 fe", fe, 0);
    pulse_rd();
    wait_tend();
    cfg(32'h0000_0007);

    // Write while thre=0 is dropped
    send(32'h0000_00A5);
    wait_thre();
    send(32'h0000_005A);
    chk("thre low with pending", thre, 0);
    send(32'h0000_00FF);
    wait_dv("ign first");
    chk("ign q A5", q, 8'hA5);
    pulse_rd();
    wait_dv("ign second");
    chk("ign q 5A", q, 8'h5A);
    pulse_rd();
    wait_tend();
    cycles(100);
    chk("ignored byte not sent", dv, 0);

    // Reset in the middle of a frame
    send(32'h0000_007E);
    wait_dv("pre-reset");
    wait_tend();
    send(32'h0000_0000);
    cycles(20);
    chk("txd low mid frame", txd, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset txd", txd, 1);
    chk("reset dv", dv, 0);
    chk("reset thre", thre, 1);
    chk("reset tend", tend, 1);
    chk("reset q", q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(200);
    chk("no partial byte", dv, 0);
    chk("txd idle after reset", txd, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
